// File: rtl/sequence_detector_pkg.sv
// Shared types and default sizing for the sequence detector scheduler.
package sequence_detector_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CLEAR = 3'd1,
    SHIFT = 3'd2,
    DRAIN = 3'd3,
    RESP  = 3'd4
  } state_e;

  localparam int DEF_NUM_REQ    = 4;
  localparam int DEF_FRAME_BITS = 8;
  localparam int DEF_CNT_W      = 4;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant plus index, searching from a rotating
// pointer that moves past the winner whenever a grant is actually taken.
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               en_i,
  input  logic [NUM_REQ-1:0] req_i,
  output logic [NUM_REQ-1:0] gnt_o,
  output logic [ID_W-1:0]    idx_o,
  output logic               any_o
);

  logic [ID_W-1:0] ptr_q;
  logic [ID_W-1:0] ptr_d;

  // First active request at or after the pointer, wrapping around.
  always_comb begin
    int   cand;
    logic found;
    gnt_o = '0;
    idx_o = '0;
    found = 1'b0;
    cand  = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cand = (int'(ptr_q) + i) % NUM_REQ;
      if (!found && req_i[cand]) begin
        found       = 1'b1;
        gnt_o[cand] = 1'b1;
        idx_o       = ID_W'(cand);
      end
    end
    any_o = found;
  end

  // Pointer moves to the requester after the winner only on a taken grant.
  always_comb begin
    ptr_d = ptr_q;
    if (en_i && any_o) begin
      ptr_d = ID_W'((int'(idx_o) + 1) % NUM_REQ);
    end
  end

  // Pointer register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/sequence_detector_sched.sv
// Shares one serial sequence detector among NUM_REQ requesters: grant one
// frame, clear the detector, shift the frame MSB-first, count detector hits
// and return the saturated count tagged with the requester index.
module sequence_detector_sched
  import sequence_detector_pkg::*;
#(
  parameter int NUM_REQ    = DEF_NUM_REQ,
  parameter int FRAME_BITS = DEF_FRAME_BITS,
  parameter int CNT_W      = DEF_CNT_W,
  parameter int ID_W       = $clog2(NUM_REQ)
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic [NUM_REQ-1:0]             req_valid,
  input  logic [NUM_REQ*FRAME_BITS-1:0]  req_data,
  output logic [NUM_REQ-1:0]             req_ready,
  output logic                           det_reset,
  output logic                           det_sequence_in,
  input  logic                           det_detector_out,
  output logic                           rsp_valid,
  output logic [ID_W-1:0]                rsp_id,
  output logic [CNT_W-1:0]               rsp_hits,
  input  logic                           rsp_ready
);

  localparam int BC_W = (FRAME_BITS > 1) ? $clog2(FRAME_BITS) : 1;
  localparam logic [BC_W-1:0] LAST_BIT = BC_W'(FRAME_BITS - 1);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  state_e                  state_q,     state_d;
  logic [FRAME_BITS-1:0]   frame_q,     frame_d;
  logic [BC_W-1:0]         bit_cnt_q,   bit_cnt_d;
  logic [CNT_W-1:0]        hits_q,      hits_d;
  logic [ID_W-1:0]         id_q,        id_d;
  logic [NUM_REQ-1:0]      req_ready_q, req_ready_d;
  logic                    det_reset_q, det_reset_d;
  logic                    det_seq_q,   det_seq_d;
  logic                    rsp_valid_q, rsp_valid_d;

  logic                    arb_en;
  logic [NUM_REQ-1:0]      arb_gnt;
  logic [ID_W-1:0]         arb_idx;
  logic                    arb_any;
  logic                    sample;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_arb (
    .clock (clock),
    .reset (reset),
    .en_i  (arb_en),
    .req_i (req_valid),
    .gnt_o (arb_gnt),
    .idx_o (arb_idx),
    .any_o (arb_any)
  );

  // Next-state logic; every output register is loaded from a decode of the
  // next state so the outputs line up with the state they belong to.
  always_comb begin
    state_d     = state_q;
    frame_d     = frame_q;
    bit_cnt_d   = bit_cnt_q;
    hits_d      = hits_q;
    id_d        = id_q;
    req_ready_d = '0;
    arb_en      = 1'b0;
    sample      = 1'b0;

    case (state_q)
      IDLE: begin
        // A grant issued last edge is being presented now; move on without
        // re-arbitrating so the pulse stays one cycle wide.
        if (req_ready_q != '0) begin
          state_d = CLEAR;
        end else begin
          arb_en = 1'b1;
        end
      end
      CLEAR: begin
        state_d   = SHIFT;
        bit_cnt_d = '0;
      end
      SHIFT: begin
        // Detector output in SHIFT cycle 0 still reflects the cleared state.
        sample = (bit_cnt_q != '0);
        if (bit_cnt_q == LAST_BIT) begin
          state_d = DRAIN;
        end else begin
          bit_cnt_d = bit_cnt_q + BC_W'(1);
        end
      end
      DRAIN: begin
        sample  = 1'b1;
        state_d = RESP;
      end
      RESP: begin
        // Arbitrating on the accepting edge puts the next grant in the very
        // next cycle.
        if (rsp_ready) begin
          state_d = IDLE;
          arb_en  = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (arb_en && arb_any) begin
      req_ready_d = arb_gnt;
      frame_d     = req_data[arb_idx*FRAME_BITS +: FRAME_BITS];
      id_d        = arb_idx;
      hits_d      = '0;
    end

    if (sample && det_detector_out) begin
      hits_d = sat_inc(hits_q);
    end

    det_reset_d = (state_d == CLEAR);
    rsp_valid_d = (state_d == RESP);
    det_seq_d   = 1'b0;
    if (state_d == SHIFT) begin
      det_seq_d = frame_q[FRAME_BITS-1];
      frame_d   = frame_q << 1;
    end
  end

  // State and output registers; reset discards any frame in flight.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      frame_q     <= '0;
      bit_cnt_q   <= '0;
      hits_q      <= '0;
      id_q        <= '0;
      req_ready_q <= '0;
      det_reset_q <= 1'b1;
      det_seq_q   <= 1'b0;
      rsp_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      frame_q     <= frame_d;
      bit_cnt_q   <= bit_cnt_d;
      hits_q      <= hits_d;
      id_q        <= id_d;
      req_ready_q <= req_ready_d;
      det_reset_q <= det_reset_d;
      det_seq_q   <= det_seq_d;
      rsp_valid_q <= rsp_valid_d;
    end
  end

  assign req_ready       = req_ready_q;
  assign det_reset       = det_reset_q;
  assign det_sequence_in = det_seq_q;
  assign rsp_valid       = rsp_valid_q;
  assign rsp_id          = id_q;
  assign rsp_hits        = hits_q;

endmodule

// File: tb/tb_sequence_detector_sched.sv
// Bench for sequence_detector_sched with a behavioural Moore 1011 detector.
module tb_sequence_detector_sched;

  localparam int NR = 4;
  localparam int FB = 8;
  localparam int CW = 4;
  localparam int IW = 2;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  logic [NR-1:0]    req_valid;
  logic [NR*FB-1:0] req_data;
  logic [NR-1:0]    req_ready;
  logic             det_reset;
  logic             det_sequence_in;
  logic             det_detector_out;
  logic             rsp_valid;
  logic [IW-1:0]    rsp_id;
  logic [CW-1:0]    rsp_hits;
  logic             rsp_ready;

  logic [NR-1:0]    s_req_valid;
  logic [NR*FB-1:0] s_req_data;
  logic [NR-1:0]    s_req_ready;
  logic             s_det_reset;
  logic             s_det_sequence_in;
  logic             s_det_detector_out;
  logic             s_rsp_valid;
  logic [IW-1:0]    s_rsp_id;
  logic [0:0]       s_rsp_hits;
  logic             s_rsp_ready;

  sequence_detector_sched #(.NUM_REQ(NR), .FRAME_BITS(FB), .CNT_W(CW), .ID_W(IW)) dut (
    .clock(clock), .reset(reset), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .det_reset(det_reset), .det_sequence_in(det_sequence_in),
    .det_detector_out(det_detector_out), .rsp_valid(rsp_valid), .rsp_id(rsp_id),
    .rsp_hits(rsp_hits), .rsp_ready(rsp_ready)
  );

  sequence_detector_sched #(.NUM_REQ(NR), .FRAME_BITS(FB), .CNT_W(1), .ID_W(IW)) dut_sat (
    .clock(clock), .reset(reset), .req_valid(s_req_valid), .req_data(s_req_data),
    .req_ready(s_req_ready), .det_reset(s_det_reset), .det_sequence_in(s_det_sequence_in),
    .det_detector_out(s_det_detector_out), .rsp_valid(s_rsp_valid), .rsp_id(s_rsp_id),
    .rsp_hits(s_rsp_hits), .rsp_ready(s_rsp_ready)
  );

  // Overlapping 1011 Moore detector: state 4 means "1011 just seen".
  function automatic logic [2:0] det_next(input logic [2:0] s, input logic b);
    case (s)
      3'd0:    return b ? 3'd1 : 3'd0;
      3'd1:    return b ? 3'd1 : 3'd2;
      3'd2:    return b ? 3'd3 : 3'd0;
      3'd3:    return b ? 3'd4 : 3'd2;
      default: return b ? 3'd1 : 3'd2;
    endcase
  endfunction

  logic [2:0] dstate   = 3'd0;
  logic [2:0] s_dstate = 3'd0;
  always @(posedge clock) dstate   <= det_reset   ? 3'd0 : det_next(dstate, det_sequence_in);
  always @(posedge clock) s_dstate <= s_det_reset ? 3'd0 : det_next(s_dstate, s_det_sequence_in);
  assign det_detector_out   = (dstate == 3'd4);
  assign s_det_detector_out = (s_dstate == 3'd4);

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  typedef struct {
    logic [NR-1:0] gnt;
    logic [FB-1:0] frame;
    logic [IW-1:0] id;
    logic [CW-1:0] hits;
  } item_t;

  item_t      exp_q[$];
  logic [2:0] s_exp_q[$];

  task automatic push_item(input int r, input logic [FB-1:0] f, input int h);
    item_t it;
    it.gnt    = '0;
    it.gnt[r] = 1'b1;
    it.frame  = f;
    it.id     = IW'(r);
    it.hits   = CW'(h);
    exp_q.push_back(it);
  endtask

  // Scoreboard monitor for the main instance.
  initial begin
    item_t         cur;
    bit            cur_act;
    int            gnt_cyc;
    int            off;
    logic          prev_valid;
    logic [IW-1:0] held_id;
    logic [CW-1:0] held_hits;
    cur_act    = 0;
    gnt_cyc    = 0;
    prev_valid = 1'b0;
    held_id    = '0;
    held_hits  = '0;
    forever begin
      @(negedge clock);
      if (!reset) begin
        cur_act    = 0;
        prev_valid = 1'b0;
      end else begin
        if (req_ready !== '0) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_grant", 32'(req_ready), 32'd0);
          end else begin
            cur = exp_q.pop_front();
            chk("grant", 32'(req_ready), 32'(cur.gnt));
            cur_act = 1;
            gnt_cyc = cyc;
          end
        end else if (cur_act) begin
          off = cyc - gnt_cyc;
          if (off == 1) chk("det_reset_clear", 32'(det_reset), 32'd1);
          if (off == 2) chk("det_reset_low", 32'(det_reset), 32'd0);
          if (off >= 2 && off <= FB + 1)
            chk("serial_bit", 32'(det_sequence_in), 32'(cur.frame[FB+1-off]));
        end
        if (rsp_valid && !prev_valid) begin
          if (!cur_act) begin
            chk("unexpected_rsp", 32'(rsp_valid), 32'd0);
          end else begin
            chk("rsp_latency", 32'(cyc - gnt_cyc), 32'(FB + 3));
            chk("rsp_id", 32'(rsp_id), 32'(cur.id));
            chk("rsp_hits", 32'(rsp_hits), 32'(cur.hits));
            held_id   = cur.id;
            held_hits = cur.hits;
            cur_act   = 0;
          end
        end else if (rsp_valid && prev_valid) begin
          chk("rsp_id_stable", 32'(rsp_id), 32'(held_id));
          chk("rsp_hits_stable", 32'(rsp_hits), 32'(held_hits));
          chk("no_grant_in_resp", 32'(req_ready), 32'd0);
        end
        prev_valid = rsp_valid;
      end
    end
  end

  // Scoreboard monitor for the 1-bit-count instance.
  initial begin
    logic s_prev;
    s_prev = 1'b0;
    forever begin
      @(negedge clock);
      if (!reset) begin
        s_prev = 1'b0;
      end else begin
        if (s_rsp_valid && !s_prev) begin
          if (s_exp_q.size() == 0) chk("sat_unexpected_rsp", 32'(s_rsp_valid), 32'd0);
          else chk("sat_rsp", 32'({s_rsp_id, s_rsp_hits}), 32'(s_exp_q.pop_front()));
        end
        s_prev = s_rsp_valid;
      end
    end
  end

  task automatic wait_grant(output int gc);
    bit found;
    found = 0;
    gc    = -1;
    for (int i = 0; i < 40 && !found; i++) begin
      @(negedge clock);
      if (req_ready !== '0) begin
        found = 1;
        gc    = cyc;
      end
    end
    if (!found) chk("grant_timeout", 32'd1, 32'd0);
  endtask

  task automatic wait_rsp_done();
    bit seen, done;
    seen = 0;
    done = 0;
    for (int i = 0; i < 60 && !done; i++) begin
      @(negedge clock);
      if (rsp_valid) seen = 1;
      else if (seen) done = 1;
    end
    if (!done) chk("rsp_timeout", 32'd1, 32'd0);
  endtask

  task automatic send(input int r, input logic [FB-1:0] f, input int h);
    int gc;
    req_data[r*FB +: FB] = f;
    push_item(r, f, h);
    req_valid[r] = 1'b1;
    wait_grant(gc);
    req_valid[r] = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int g[5];
    int gc;
    int acc;
    bit f;
    reset       = 1'b0;
    req_valid   = '0;
    req_data    = '0;
    rsp_ready   = 1'b1;
    s_req_valid = '0;
    s_req_data  = '0;
    s_rsp_ready = 1'b1;

    repeat (3) @(negedge clock);
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    chk("rst_det_reset", 32'(det_reset), 32'd1);
    chk("rst_det_seq", 32'(det_sequence_in), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_id", 32'(rsp_id), 32'd0);
    chk("rst_rsp_hits", 32'(rsp_hits), 32'd0);
    reset = 1'b1;
    @(negedge clock);
    chk("rst_release_det_reset", 32'(det_reset), 32'd0);

    // Single frame and zero-hit frames.
    send(2, 8'hBB, 2);
    wait_rsp_done();
    send(3, 8'h00, 0);
    wait_rsp_done();
    send(1, 8'hFF, 0);
    wait_rsp_done();

    // Reset in the middle of SHIFT.
    send(2, 8'hBB, 2);
    repeat (5) @(negedge clock);
    #2 reset = 1'b0;
    #1;
    chk("midrst_req_ready", 32'(req_ready), 32'd0);
    chk("midrst_det_reset", 32'(det_reset), 32'd1);
    chk("midrst_det_seq", 32'(det_sequence_in), 32'd0);
    chk("midrst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("midrst_rsp_id", 32'(rsp_id), 32'd0);
    chk("midrst_rsp_hits", 32'(rsp_hits), 32'd0);
    repeat (2) @(negedge clock);
    chk("midrst_hold_det_reset", 32'(det_reset), 32'd1);
    reset = 1'b1;
    @(negedge clock);
    chk("midrst_release_det_reset", 32'(det_reset), 32'd0);
    repeat (20) @(negedge clock);

    // Round robin with every requester asserted and rsp_ready high.
    req_data = {8'hB6, 8'h2D, 8'h0B, 8'hBB};
    push_item(0, 8'hBB, 2);
    push_item(1, 8'h0B, 1);
    push_item(2, 8'h2D, 1);
    push_item(3, 8'hB6, 2);
    push_item(0, 8'hBB, 2);
    req_valid = 4'hF;
    for (int i = 0; i < 5; i++) wait_grant(g[i]);
    req_valid = '0;
    for (int i = 1; i < 5; i++) chk("rr_spacing", 32'(g[i] - g[i-1]), 32'd12);
    wait_rsp_done();

    // Backpressure: response held for 5 edges, next grant right after accept.
    rsp_ready = 1'b0;
    req_data  = {8'h00, 8'h00, 8'h2D, 8'hBB};
    push_item(1, 8'h2D, 1);
    push_item(0, 8'hBB, 2);
    req_valid = 4'b0011;
    wait_grant(gc);
    req_valid = 4'b0001;
    f = 0;
    for (int i = 0; i < 40 && !f; i++) begin
      @(negedge clock);
      if (rsp_valid) f = 1;
    end
    if (!f) chk("bp_rsp_timeout", 32'd1, 32'd0);
    repeat (5) @(negedge clock);
    rsp_ready = 1'b1;
    acc = cyc;
    wait_grant(gc);
    req_valid = '0;
    chk("bp_next_grant_cycle", 32'(gc), 32'(acc + 1));
    wait_rsp_done();

    // Saturation on the 1-bit-count instance.
    s_req_data[FB-1:0] = 8'hBB;
    s_exp_q.push_back({2'd0, 1'b1});
    s_req_valid = 4'b0001;
    f = 0;
    for (int i = 0; i < 40 && !f; i++) begin
      @(negedge clock);
      if (s_req_ready !== '0) f = 1;
    end
    if (!f) chk("sat_grant_timeout", 32'd1, 32'd0);
    else chk("sat_grant", 32'(s_req_ready), 32'd1);
    s_req_valid = '0;
    repeat (20) @(negedge clock);

    chk("exp_q_empty", 32'(exp_q.size()), 32'd0);
    chk("sat_q_empty", 32'(s_exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sequence_detector_sched.md
# sequence_detector_sched

Round-robin scheduler that shares one serial `sequence_detector` instance among `NUM_REQ` requesters. Each request carries a `FRAME_BITS`-bit frame. The block performs four steps per request:
- clears the detector;
- shifts the frame into it MSB-first;
- counts `detector_out` hits;
- returns the hit count tagged with the requester ID.

It sits between the channel front-ends and the detector datapath and owns the detector's reset and serial input.

## Interface
- `NUM_REQ`, default 4: number of requesters (≥2).
- `FRAME_BITS`, default 8: bits per frame.
- `CNT_W`, default 4: hit-count width; the count saturates.
- `ID_W`, default `$clog2(NUM_REQ)`: requester ID width.

- `clock`, input, 1: single clock; all state updates on the rising edge.
- `reset`, input, 1: asynchronous, active-low reset.
- `req_valid`, input, `NUM_REQ`: per-requester request.
- `req_data`, input, `NUM_REQ*FRAME_BITS`: frame for requester i in bits `[i*FRAME_BITS +: FRAME_BITS]`.
- `req_ready`, output, `NUM_REQ`: one-hot one-cycle grant; data is captured on this edge.
- `det_reset`, output, 1: active-high reset to the detector.
- `det_sequence_in`, output, 1: serial bit to the detector.
- `det_detector_out`, input, 1: detector output, Moore, valid the cycle after each bit.
- `rsp_valid`, output, 1: response available.
- `rsp_id`, output, `ID_W`: granted requester index.
- `rsp_hits`, output, `CNT_W`: hits counted in the frame.
- `rsp_ready`, input, 1: response accepted.

## Operation
- **FSM states:** IDLE, CLEAR, SHIFT, DRAIN, RESP.
- **IDLE:** if any `req_valid`, the arbiter grants one requester and the block does the following:
  - pulses its `req_ready` bit;
  - latches its frame into the shift register and its index into `rsp_id`;
  - zeroes the hit counter;
  - moves to CLEAR.
- If no `req_valid` in IDLE, the FSM stays in IDLE.
- **Arbitration:** round-robin. The pointer starts at 0 after reset and moves to (granted+1) mod `NUM_REQ` after each grant. The search starts at the pointer, so the highest priority goes to the requester after the last grant.
- **CLEAR** lasts one cycle. `det_reset` = 1, then the FSM goes to SHIFT.
- **SHIFT** lasts `FRAME_BITS` cycles, driven by a bit counter from 0 to `FRAME_BITS-1`.
  - `det_sequence_in` = frame bit `[FRAME_BITS-1-k]` in SHIFT cycle k.
  - On the last bit the FSM goes to DRAIN.
- **Hit sampling:** `det_detector_out` is sampled at the edge ending SHIFT cycles 1..`FRAME_BITS-1` and at the edge ending DRAIN. Each sample of 1 increments the hit counter, saturating at 2^`CNT_W`-1. The input is ignored in IDLE, CLEAR and RESP.
- **DRAIN** lasts one cycle, then the FSM goes to RESP.
- **RESP:** `rsp_valid` = 1. `rsp_id` and `rsp_hits` are stable until the edge where `rsp_ready` = 1; on that edge the FSM goes to IDLE.
  - `rsp_valid` is low in every other state.
  - No new grant is made in the RESP cycle.
- `det_sequence_in` = 0 outside SHIFT. `det_reset` = 0 outside CLEAR.
- `req_valid` may drop while not granted with no effect. Requests are not queued internally.

## Timing
- **Reset values** (while `reset` is low): state IDLE, rotating pointer 0, `req_ready` 0, `det_reset` 1, `det_sequence_in` 0, `rsp_valid` 0, `rsp_id` 0, `rsp_hits` 0.
- **Leaving reset:** `det_reset` falls to 0 at the first edge after `reset` goes high.
- **Reset mid-operation:** takes effect immediately, discards the in-flight frame, and issues no response.
- **Latency**, with the grant at cycle 0:
  - CLEAR at cycle 1;
  - SHIFT at cycles 2..`FRAME_BITS`+1;
  - DRAIN at cycle `FRAME_BITS`+2;
  - `rsp_valid` first high at cycle `FRAME_BITS`+3 (11 for defaults).
- **Throughput:** with `rsp_ready` tied high, the next grant comes at the earliest at cycle `FRAME_BITS`+4, giving one frame per 12 cycles for defaults.
- **Outputs:** all outputs are registered. `req_ready` is high only in the IDLE grant cycle.

## Structure
- **Package `sequence_detector_pkg`:** state enum (IDLE, CLEAR, SHIFT, DRAIN, RESP) and default parameter constants.
- **Sub-module `rr_arbiter`:** `NUM_REQ`-wide round-robin grant with an enable input.
  - It outputs a one-hot grant and an index.
  - It holds the rotating pointer internally and advances it only when enable and any request are both present.
- **Top level:** FSM, shift register, bit counter, saturating hit counter and response registers.

## Test plan
The bench uses a behavioural Moore detector for overlapping `1011`.
- **Reset:** `reset` low mid-SHIFT -> all outputs return to their reset values at once, no `rsp_valid` follows, and `det_reset` is 0 one edge after `reset` goes high.
- **Single frame:** requester 2 sends 8'hBB with `rsp_ready`=1 -> `req_ready`=4'b0100 at cycle 0; `det_reset` high at cycle 1; serial bits 1,0,1,1,1,0,1,1 over cycles 2..9; at cycle 11, `rsp_valid`=1, `rsp_id`=2, `rsp_hits`=2.
- **Zero hits:** frame 8'h00 or 8'hFF -> `rsp_hits`=0, with the same latency.
- **Round robin:** all four `req_valid` held high -> grants go 0,1,2,3,0 and responses carry IDs 0,1,2,3,0.
- **Backpressure:** `rsp_ready` held low for 5 cycles -> `rsp_valid`, `rsp_id` and `rsp_hits` are stable, no new `req_ready` appears, and the next grant comes the cycle after acceptance.
- **Saturation:** `CNT_W`=1 with frame 8'hBB -> `rsp_hits`=1.
